// File: rtl/calendar_counter.sv
// Month/day/weekday calendar stepping one day per tick, with validated synchronous load.
// Load takes priority over tick; illegal loads are rejected with a one-cycle load_err pulse.
module calendar_counter #(
  parameter int START_MONTH = 1,
  parameter int START_DAY   = 1,
  parameter int START_WDAY  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       leap,
  input  logic       load,
  input  logic [3:0] load_month,
  input  logic [4:0] load_day,
  input  logic [2:0] load_wday,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [2:0] wday,
  output logic       long_month,
  output logic       month_end,
  output logic       year_wrap,
  output logic       load_err
);

  function automatic logic [4:0] mlen(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                    mlen = 5'd28 + {4'd0, lp};
      4'd4, 4'd6, 4'd9, 4'd11: mlen = 5'd30;
      default:                 mlen = 5'd31;
    endcase
  endfunction

  logic load_ok;

  always_comb begin
    long_month = 1'b0;
    case (month)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: long_month = 1'b1;
      default:                                    long_month = 1'b0;
    endcase
  end

  // >= rather than == so a stale Feb 29 still rolls over once leap drops
  assign month_end = (day >= mlen(month, leap));

  assign load_ok = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                   (load_day >= 5'd1) && (load_day <= mlen(load_month, leap)) &&
                   (load_wday <= 3'd6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      month     <= 4'(START_MONTH);
      day       <= 5'(START_DAY);
      wday      <= 3'(START_WDAY);
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
    end else if (load) begin
      year_wrap <= 1'b0;
      load_err  <= !load_ok;
      if (load_ok) begin
        month <= load_month;
        day   <= load_day;
        wday  <= load_wday;
      end
    end else if (tick) begin
      load_err <= 1'b0;
      wday     <= (wday == 3'd6) ? 3'd0 : wday + 3'd1;
      if (month_end) begin
        day       <= 5'd1;
        month     <= (month == 4'd12) ? 4'd1 : month + 4'd1;
        year_wrap <= (month == 4'd12);
      end else begin
        day       <= day + 5'd1;
        year_wrap <= 1'b0;
      end
    end else begin
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
    end
  end

endmodule
